// File: rtl/load_store_unit_if.sv
// Request/response/data-memory bundle for load_store_unit.
// slave = the unit itself, master = the pipeline/memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_we;
    logic [31:0] mem_dout;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_din, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_din, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-request load/store unit in front of a 2^ADDR_W x 32-bit data memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them down.
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_din_q, mem_din_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_fault_q, rsp_fault_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [1:0]          lane_q, lane_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                addr_out_of_range;
    logic                misaligned;
    logic                req_fault;

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] m;
        m = word;
        case (size)
            2'b00: m[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) m[31:16] = wdata[15:0];
                else         m[15:0]  = wdata[15:0];
            end
            default: m = wdata;
        endcase
        return m;
    endfunction

    assign addr_out_of_range = |(bus.req_addr >> (ADDR_W + 2));

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_fault = (bus.req_size == 2'b11) || addr_out_of_range || misaligned;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d       = bus.req_we;
                    size_d     = bus.req_size;
                    signed_d   = bus.req_signed;
                    lane_d     = bus.req_addr[1:0];
                    wdata_d    = bus.req_wdata;
                    mem_addr_d = bus.req_addr[ADDR_W+1:2];
                    if (req_fault) begin
                        state_d     = RESP;
                        rsp_fault_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (bus.req_we && (bus.req_size == 2'b10)) begin
                        state_d   = WR;
                        mem_din_d = bus.req_wdata;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                // Sub-word stores merge into the word just read; loads finish here.
                if (we_q) begin
                    state_d   = WR;
                    mem_din_d = merge_store(bus.mem_dout, wdata_q, size_q, lane_q);
                end else begin
                    state_d     = RESP;
                    rsp_rdata_d = extract_load(bus.mem_dout, size_q, signed_q, lane_q);
                    rsp_fault_d = 1'b0;
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_rdata_d = '0;
                rsp_fault_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q     <= we_d;
        size_q   <= size_d;
        signed_q <= signed_d;
        lane_q   <= lane_d;
        wdata_q  <= wdata_d;
    end

    // Reset gates the handshake and write strobe immediately so an aborted WR never lands.
    assign bus.req_ready = (state_q == IDLE) && !reset;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.mem_we    = (state_q == WR) && !reset;
    assign bus.mem_addr  = 32'(mem_addr_q);
    assign bus.mem_din   = mem_din_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table of requests with hand-computed results plus reset sequences.
module tb_load_store_unit;

    logic clk;
    logic reset;
    logic mem_clear;
    load_store_unit_if bus ();

    load_store_unit #(.ADDR_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Plain 32-word data memory with known preload.
    logic [31:0] mem [32];
    assign bus.mem_dout = mem[bus.mem_addr[4:0]];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[2] <= 32'h11223344;
            mem[3] <= 32'h8899AABB;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[4:0]] <= bus.mem_din;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_we_k;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdin;
    } vec_t;

    int tests;
    int fails;
    vec_t vq[$];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_fault,
                                input int exp_lat, input int exp_we_k,
                                input logic [31:0] exp_waddr, input logic [31:0] exp_wdin);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_fault = exp_fault; v.exp_lat = exp_lat;
        v.exp_we_k = exp_we_k; v.exp_waddr = exp_waddr; v.exp_wdin = exp_wdin;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        int          we_k;
        int          we_cnt;
        logic [31:0] rdata;
        logic        flt;
        logic [31:0] waddr;
        logic [31:0] wdin;
        string       tag;
        lat = 0; we_k = 0; we_cnt = 0; rdata = '0; flt = 1'b0; waddr = '0; wdin = '0;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = v.we;
        bus.req_size   = v.size;
        bus.req_signed = v.sgn;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_we) begin
                we_cnt++;
                if (we_k == 0) begin
                    we_k  = k;
                    waddr = bus.mem_addr;
                    wdin  = bus.mem_din;
                end
            end
            if (bus.rsp_valid) begin
                lat   = k;
                rdata = bus.rsp_rdata;
                flt   = bus.rsp_fault;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rdata"}, rdata, v.exp_rdata);
        chk({tag, "_fault"}, 32'(flt), 32'(v.exp_fault));
        chk({tag, "_we_cycle"}, 32'(we_k), 32'(v.exp_we_k));
        chk({tag, "_we_count"}, 32'(we_cnt), (v.exp_we_k != 0) ? 32'd1 : 32'd0);
        if (v.exp_we_k != 0) begin
            chk({tag, "_waddr"}, waddr, v.exp_waddr);
            chk({tag, "_wdin"}, wdin, v.exp_wdin);
        end
    endtask

    initial begin
        logic saw_rsp;
        logic saw_we;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        mem_clear = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        //      we    size   sgn   addr      wdata         rdata         flt  lat we_k waddr wdin
        vq.push_back(mk(1'b0, 2'b00, 1'b1, 32'h0E, 32'h0,        32'hFFFFFF99, 1'b0, 2, 0, 0, 0));
        vq.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0E, 32'h0,        32'h00000099, 1'b0, 2, 0, 0, 0));
        vq.push_back(mk(1'b0, 2'b01, 1'b1, 32'h0C, 32'h0,        32'hFFFFAABB, 1'b0, 2, 0, 0, 0));
        vq.push_back(mk(1'b0, 2'b10, 1'b1, 32'h0C, 32'h0,        32'h8899AABB, 1'b0, 2, 0, 0, 0));
        vq.push_back(mk(1'b1, 2'b00, 1'b0, 32'h09, 32'hABCDEFEE, 32'h0,        1'b0, 3, 2, 2, 32'h1122EE44));
        vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h1122EE44, 1'b0, 2, 0, 0, 0));
        vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 4, 32'hDEADBEEF));
        vq.push_back(mk(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 2, 0, 0, 0));
        vq.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, 0, 0));
        vq.push_back(mk(1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h000000DE, 1'b0, 2, 0, 0, 0));
        vq.push_back(mk(1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 0, 0, 0));
        vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0));
        vq.push_back(mk(1'b0, 2'b11, 1'b0, 32'h04, 32'h0,        32'h0,        1'b1, 1, 0, 0, 0));
        vq.push_back(mk(1'b1, 2'b10, 1'b0, 32'h84, 32'h12345678, 32'h0,        1'b1, 1, 0, 0, 0));
`ifdef LSU_MISALIGN_TRAP_EN
        vq.push_back(mk(1'b1, 2'b01, 1'b0, 32'h05, 32'hFFFF1234, 32'h0,        1'b1, 1, 0, 0, 0));
        vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'h0,        1'b0, 2, 0, 0, 0));
`else
        vq.push_back(mk(1'b1, 2'b01, 1'b0, 32'h05, 32'hFFFF1234, 32'h0,        1'b0, 3, 2, 1, 32'h00001234));
        vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        32'h00001234, 1'b0, 2, 0, 0, 0));
`endif
        vq.push_back(mk(1'b1, 2'b00, 1'b0, 32'h1F, 32'h0000007F, 32'h0,        1'b0, 3, 2, 7, 32'h7F000000));
        vq.push_back(mk(1'b1, 2'b01, 1'b0, 32'h1E, 32'h00005678, 32'h0,        1'b0, 3, 2, 7, 32'h56780000));
        vq.push_back(mk(1'b0, 2'b10, 1'b0, 32'h1C, 32'h0,        32'h56780000, 1'b0, 2, 0, 0, 0));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_din", bus.mem_din, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk);
        chk("rst_release_ready", 32'(bus.req_ready), 32'd1);

        // First vector, then confirm the response fields hold after the pulse.
        run_vec(0, vq[0]);
        @(negedge clk);
        chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("hold_rsp_rdata", bus.rsp_rdata, 32'hFFFFFF99);
        for (int i = 1; i < vq.size(); i++) run_vec(i, vq[i]);

        // Reset during the WR cycle of a byte store to word 6.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h18;
        bus.req_wdata  = 32'h000000AA;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort_ready_in_reset", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
        saw_rsp = bus.rsp_valid;
        saw_we  = bus.mem_we;
        repeat (3) begin
            @(negedge clk);
            saw_rsp = saw_rsp | bus.rsp_valid;
            saw_we  = saw_we | bus.mem_we;
        end
        chk("abort_no_rsp", 32'(saw_rsp), 32'd0);
        chk("abort_no_we", 32'(saw_we), 32'd0);
        run_vec(100, mk(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 32'h0, 1'b0, 2, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
